instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ifu_pkg.sv | 19 +
 rtl/pc_next_calc.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, instruction field
// positions and the default sequential PC step.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } ifu_state_t;

  localparam int INSTR_WIDTH     = 32;
  localparam int OPCODE_MSB      = 31;
  localparam int OPCODE_LSB      = 24;
  localparam int OFFSET_MSB      = 23;
  localparam int OFFSET_LSB      = 16;
  localparam int OFFSET_W        = OFFSET_MSB - OFFSET_LSB + 1;
  localparam int DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump > beq > bne, all arithmetic modulo 2^32.
// The bne path is only honoured when IFU_BNE_EN is defined.
module pc_next_calc
  import ifu_pkg::*;
#(
  parameter int PC_STEP = DEFAULT_PC_STEP
) (
  input  logic [INSTR_WIDTH-1:0] pc,
  input  logic [OFFSET_W-1:0]    offset,
  input  logic                   jump,
  input  logic                   beq,
  input  logic                   bne,
  input  logic                   zero,
  output logic [INSTR_WIDTH-1:0] next_pc
);

  // Word offset: sign-extend the byte field, then scale to bytes.
  function automatic logic signed [INSTR_WIDTH-1:0] word_offset(input logic [OFFSET_W-1:0] off);
    logic signed [INSTR_WIDTH-1:0] ext;
    ext = {{(INSTR_WIDTH-OFFSET_W-2){off[OFFSET_W-1]}}, off, 2'b00};
    return ext;
  endfunction

  logic [INSTR_WIDTH-1:0]        step;
  logic [INSTR_WIDTH-1:0]        seq_pc;
  logic signed [INSTR_WIDTH-1:0] off_ext;
  logic [INSTR_WIDTH-1:0]        target;
  logic                          bne_taken;

  assign step    = INSTR_WIDTH'(PC_STEP);
  assign seq_pc  = pc + step;
  assign off_ext = word_offset(offset);
  assign target  = seq_pc + $unsigned(off_ext);

`ifdef IFU_BNE_EN
  assign bne_taken = bne & ~zero;
`else
  logic bne_unused;
  assign bne_unused = bne;
  assign bne_taken  = 1'b0;
`endif

  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = target;
    else if (beq)
      next_pc = zero ? target : seq_pc;
    else if (bne_taken)
      next_pc = target;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH (wait out IMEM_BUSYWAIT) -> EXEC -> FETCH.
// Optional macro IFU_BNE_EN enables the bne branch path in pc_next_calc.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCHENABLE,
  input  logic        JUMPENABLE,
  input  logic        BRANCH_NOTEQUAL,
  input  logic        ZERO,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID
);

  ifu_state_t             state;
  logic [INSTR_WIDTH-1:0] pc_p0;
  logic                   read_p0;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic                   vld_p1;
  logic [INSTR_WIDTH-1:0] next_pc;

  // Enables and ZERO reach the calculator every cycle but only EXEC consumes next_pc.
  pc_next_calc #(
    .PC_STEP (PC_STEP)
  ) u_pc_next_calc (
    .pc      (pc_p0),
    .offset  (instr_p1[OFFSET_MSB:OFFSET_LSB]),
    .jump    (JUMPENABLE),
    .beq     (BRANCHENABLE),
    .bne     (BRANCH_NOTEQUAL),
    .zero    (ZERO),
    .next_pc (next_pc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      pc_p0    <= RESET_VECTOR;
      read_p0  <= 1'b0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          read_p0 <= 1'b1;
          vld_p1  <= 1'b0;
        end
        // p0 -> p1: capture the word once memory is ready
        FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            instr_p1 <= IMEM_READDATA;
            vld_p1   <= 1'b1;
            read_p0  <= 1'b0;
            state    <= EXEC;
          end
        end
        // p1 -> p0: commit the next PC and start the following fetch
        EXEC: begin
          pc_p0   <= next_pc;
          vld_p1  <= 1'b0;
          read_p0 <= 1'b1;
          state   <= FETCH;
        end
        default: begin
          state   <= IDLE;
          read_p0 <= 1'b0;
          vld_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_READ    = read_p0;
  assign IMEM_ADDRESS = pc_p0;
  assign PC           = pc_p0;
  assign INSTRUCTION  = instr_p1;
  assign INSTR_VALID  = vld_p1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; expectations follow IFU_BNE_EN when defined.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BRANCHENABLE;
  logic        JUMPENABLE;
  logic        BRANCH_NOTEQUAL;
  logic        ZERO;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_exp;
  logic [31:0] last_instr;
  logic [31:0] t;

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BRANCHENABLE    (BRANCHENABLE),
    .JUMPENABLE      (JUMPENABLE),
    .BRANCH_NOTEQUAL (BRANCH_NOTEQUAL),
    .ZERO            (ZERO),
    .IMEM_READDATA   (IMEM_READDATA),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .IMEM_READ       (IMEM_READ),
    .IMEM_ADDRESS    (IMEM_ADDRESS),
    .PC              (PC),
    .INSTRUCTION     (INSTRUCTION),
    .INSTR_VALID     (INSTR_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH with memory ready; leaves the DUT in the following FETCH.
  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input logic j, input logic b, input logic n, input logic z,
                           input logic [31:0] exp_next);
    IMEM_READDATA   = instr;
    IMEM_BUSYWAIT   = 1'b0;
    JUMPENABLE      = j;
    BRANCHENABLE    = b;
    BRANCH_NOTEQUAL = n;
    ZERO            = z;
    chk({tag, "_addr"}, IMEM_ADDRESS, pc_exp);
    tick();
    chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd1);
    chk({tag, "_instr"}, INSTRUCTION, instr);
    chk({tag, "_read_exec"}, {31'd0, IMEM_READ}, 32'd0);
    tick();
    chk({tag, "_pc"}, PC, exp_next);
    chk({tag, "_valid_off"}, {31'd0, INSTR_VALID}, 32'd0);
    JUMPENABLE = 0; BRANCHENABLE = 0; BRANCH_NOTEQUAL = 0; ZERO = 0;
    pc_exp     = exp_next;
    last_instr = instr;
  endtask

  initial begin
    RESET = 1'b1;
    BRANCHENABLE = 0; JUMPENABLE = 0; BRANCH_NOTEQUAL = 0; ZERO = 0;
    IMEM_READDATA = 32'h0; IMEM_BUSYWAIT = 0;
    tick();
    tick();
    chk("rst_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", INSTRUCTION, 32'h0);

    // Release reset; first edge enters FETCH at the reset vector
    IMEM_READDATA = 32'h0200_0102;
    RESET = 1'b0;
    tick();
    chk("first_read", {31'd0, IMEM_READ}, 32'd1);
    chk("first_addr", IMEM_ADDRESS, 32'h0);
    chk("first_valid_fetch", {31'd0, INSTR_VALID}, 32'd0);
    pc_exp = 32'h0;
    run_instr("seq0", 32'h0200_0102, 0, 0, 0, 0, 32'h4);
    run_instr("seq4", 32'h0100_0000, 0, 0, 0, 0, 32'h8);

    // Memory stall at 0x8 for three cycles; enables waved during FETCH must be ignored
    IMEM_BUSYWAIT = 1'b1;
    IMEM_READDATA = 32'hDEAD_BEEF;
    JUMPENABLE = 1'b1; ZERO = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_read", {31'd0, IMEM_READ}, 32'd1);
      chk("stall_addr", IMEM_ADDRESS, 32'h8);
      chk("stall_instr", INSTRUCTION, last_instr);
      chk("stall_valid", {31'd0, INSTR_VALID}, 32'd0);
      chk("stall_pc", PC, 32'h8);
    end
    JUMPENABLE = 1'b0; ZERO = 1'b0;
    // jump +1 word from 0x8 lands on 0x10
    run_instr("jmp8", 32'h0401_0000, 1, 0, 0, 0, 32'h10);

    // beq at 0x10 offset -2: taken -> 0xC, then not taken back up, then not taken -> 0x14
    run_instr("beq_taken", 32'h0BFE_0000, 0, 1, 0, 1, 32'h0C);
    run_instr("beq_nt_c", 32'h0BFE_0000, 0, 1, 0, 0, 32'h10);
    run_instr("beq_nt", 32'h0BFE_0000, 0, 1, 0, 0, 32'h14);
    run_instr("jmp14", 32'h0402_0000, 1, 0, 0, 0, 32'h20);

`ifdef IFU_BNE_EN
    run_instr("bne", 32'h0C02_0000, 0, 0, 1, 0, 32'h2C);
`else
    run_instr("bne", 32'h0C02_0000, 0, 0, 1, 0, 32'h24);
`endif

    // Reach 0xFFFF_FFF0 with a backward jump, then wrap forward
    t = 32'hFFFF_FFF0 - (pc_exp + 32'd4);
    run_instr("jmp_neg", {8'h04, t[9:2], 16'h0}, 1, 0, 0, 0, 32'hFFFF_FFF0);
    run_instr("jmp_wrap", 32'h047F_0000, 1, 0, 0, 0, 32'h0000_01F0);

    // Priority: jump wins over a not-taken beq; beq wins alongside bne
    run_instr("prio_jb", 32'h0404_0000, 1, 1, 0, 0, 32'h0000_0204);
    run_instr("prio_bn", 32'h0B03_0000, 0, 1, 1, 1, 32'h0000_0214);

    // Asynchronous reset in the middle of a stalled fetch
    IMEM_BUSYWAIT = 1'b1;
    tick();
    #2;
    RESET = 1'b1;
    #1;
    chk("async_read", {31'd0, IMEM_READ}, 32'd0);
    chk("async_pc", PC, 32'h0);
    chk("async_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("async_instr", INSTRUCTION, 32'h0);
    #1;
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("restart_read", {31'd0, IMEM_READ}, 32'd1);
    chk("restart_addr", IMEM_ADDRESS, 32'h0);
    pc_exp = 32'h0;
    run_instr("restart", 32'h0200_0102, 0, 0, 0, 0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
